// File: rtl/ipdom_split_join_ctrl_pkg.sv
// Shared types for the IPDOM divergence-stack initiator: entry layout,
// request/response records, controller state encoding and sizing helper.
package ipdom_split_join_ctrl_pkg;

   localparam int DFLT_NUM_WARPS   = 4;
   localparam int DFLT_NUM_THREADS = 4;
   localparam int DFLT_PC_WIDTH    = 32;
   localparam int DFLT_DEPTH       = 8;

   // Width of an index able to address n items, never narrower than one bit.
   function automatic int log2up(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DFLT_NW_WIDTH    = log2up(DFLT_NUM_WARPS);
   localparam int DFLT_ADDRW       = log2up(DFLT_DEPTH);
   localparam int IPDOM_WIDTH      = 2 * DFLT_NUM_THREADS + DFLT_PC_WIDTH;

   // One reconvergence record as stored in the stack.
   typedef struct packed {
      logic [DFLT_NUM_THREADS-1:0] orig_tmask;
      logic [DFLT_NUM_THREADS-1:0] else_tmask;
      logic [DFLT_PC_WIDTH-1:0]    else_pc;
   } ipdom_entry_t;

   typedef struct packed {
      logic [DFLT_NUM_THREADS-1:0] tmask;
      logic [DFLT_NUM_THREADS-1:0] pred;
      logic [DFLT_PC_WIDTH-1:0]    else_pc;
   } split_req_t;

   typedef struct packed {
      logic                   divergent;
      logic [DFLT_ADDRW-1:0]  stack_ptr;
   } join_req_t;

   typedef struct packed {
      logic [DFLT_NW_WIDTH-1:0]    wid;
      logic [DFLT_NUM_THREADS-1:0] tmask;
      logic                        pc_en;
      logic [DFLT_PC_WIDTH-1:0]    pc;
   } wctl_rsp_t;

   typedef enum logic [1:0] {
      IPDOM_IDLE     = 2'd0,
      IPDOM_JOIN_RD  = 2'd1,
      IPDOM_JOIN_POP = 2'd2
   } ipdom_state_e;

endpackage

// File: rtl/ipdom_split_join_ctrl.sv
// IPDOM split/join initiator: turns SPLIT/JOIN requests into stack push/pop
// traffic and returns a single-cycle warp-control update to the scheduler.
module ipdom_split_join_ctrl
   import ipdom_split_join_ctrl_pkg::*;
#(
   parameter int NUM_WARPS   = DFLT_NUM_WARPS,
   parameter int NUM_THREADS = DFLT_NUM_THREADS,
   parameter int PC_WIDTH    = DFLT_PC_WIDTH,
   parameter int DEPTH       = DFLT_DEPTH,
   localparam int NW_WIDTH   = log2up(NUM_WARPS),
   localparam int ADDRW      = log2up(DEPTH),
   localparam int IW         = 2 * NUM_THREADS + PC_WIDTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req_valid_i,
   output logic                       req_ready_o,
   input  logic                       req_is_split_i,
   input  logic [NW_WIDTH-1:0]        req_wid_i,
   input  logic [NUM_THREADS-1:0]     req_tmask_i,
   input  logic [NUM_THREADS-1:0]     req_pred_i,
   input  logic [PC_WIDTH-1:0]        req_else_pc_i,
   input  logic                       req_divergent_i,
   input  logic [ADDRW-1:0]           req_stack_ptr_i,
   output logic [NW_WIDTH-1:0]        stk_wid_o,
   output logic                       stk_push_o,
   output logic                       stk_pop_o,
   output logic [IW-1:0]              stk_d_val_o,
   output logic [ADDRW-1:0]           stk_rd_ptr_o,
   input  logic [IW-1:0]              stk_q_val_i,
   input  logic                       stk_q_idx_i,
   input  logic [NUM_WARPS*ADDRW-1:0] stk_wr_ptr_i,
   input  logic                       stk_empty_i,
   input  logic                       stk_full_i,
   output logic                       rsp_valid_o,
   output logic [NW_WIDTH-1:0]        rsp_wid_o,
   output logic [NUM_THREADS-1:0]     rsp_tmask_o,
   output logic                       rsp_pc_en_o,
   output logic [PC_WIDTH-1:0]        rsp_pc_o,
   output logic                       rsp_divergent_o,
   output logic [ADDRW-1:0]           rsp_stack_ptr_o
);

   ipdom_state_e state_q;
   logic [NW_WIDTH-1:0]    wid_q;
   logic [ADDRW-1:0]       rd_ptr_q;
   logic                   rsp_valid_q;
   logic [NW_WIDTH-1:0]    rsp_wid_q;
   logic [NUM_THREADS-1:0] rsp_tmask_q;
   logic                   rsp_pc_en_q;
   logic [PC_WIDTH-1:0]    rsp_pc_q;
   logic                   rsp_divergent_q;
   logic [ADDRW-1:0]       rsp_stack_ptr_q;

   logic [NUM_THREADS-1:0] taken, ntaken;
   logic                   split_div, is_idle, req_fire, join_div_fire;
   logic [ADDRW-1:0]       wr_ptr_sel;
   logic [NUM_THREADS-1:0] q_orig_tmask, q_else_tmask;
   logic [PC_WIDTH-1:0]    q_else_pc;

   assign taken     = req_tmask_i & req_pred_i;
   assign ntaken    = req_tmask_i & ~req_pred_i;
   assign split_div = (|taken) & (|ntaken);
   assign is_idle   = (state_q == IPDOM_IDLE);

   // A divergent SPLIT must stall while the warp's stack has no room.
   assign req_ready_o   = ~reset & is_idle & ~(req_is_split_i & split_div & stk_full_i);
   assign req_fire      = req_valid_i & req_ready_o;
   assign join_div_fire = req_fire & ~req_is_split_i & req_divergent_i;

   // Write pointer of the requesting warp, reported back as the SPLIT's stack slot.
   assign wr_ptr_sel = stk_wr_ptr_i[req_wid_i*ADDRW +: ADDRW];

   assign stk_wid_o    = is_idle ? req_wid_i : wid_q;
   assign stk_push_o   = req_fire & req_is_split_i & split_div;
   assign stk_pop_o    = ~reset & (state_q == IPDOM_JOIN_POP);
   assign stk_d_val_o  = {req_tmask_i, ntaken, req_else_pc_i};
   assign stk_rd_ptr_o = join_div_fire ? req_stack_ptr_i : rd_ptr_q;

   assign q_orig_tmask = stk_q_val_i[IW-1 -: NUM_THREADS];
   assign q_else_tmask = stk_q_val_i[PC_WIDTH +: NUM_THREADS];
   assign q_else_pc    = stk_q_val_i[PC_WIDTH-1:0];

   assign rsp_valid_o     = rsp_valid_q;
   assign rsp_wid_o       = rsp_wid_q;
   assign rsp_tmask_o     = rsp_tmask_q;
   assign rsp_pc_en_o     = rsp_pc_en_q;
   assign rsp_pc_o        = rsp_pc_q;
   assign rsp_divergent_o = rsp_divergent_q;
   assign rsp_stack_ptr_o = rsp_stack_ptr_q;

   // Controller FSM with registered warp-control response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IPDOM_IDLE;
         wid_q           <= '0;
         rd_ptr_q        <= '0;
         rsp_valid_q     <= 1'b0;
         rsp_wid_q       <= '0;
         rsp_tmask_q     <= '0;
         rsp_pc_en_q     <= 1'b0;
         rsp_pc_q        <= '0;
         rsp_divergent_q <= 1'b0;
         rsp_stack_ptr_q <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            IPDOM_IDLE: begin
               if (req_fire) begin
                  rsp_wid_q <= req_wid_i;
                  if (req_is_split_i) begin
                     rsp_valid_q     <= 1'b1;
                     rsp_tmask_q     <= split_div ? taken : req_tmask_i;
                     rsp_pc_en_q     <= ~|taken;
                     rsp_pc_q        <= req_else_pc_i;
                     rsp_divergent_q <= split_div;
                     rsp_stack_ptr_q <= wr_ptr_sel;
                  end else if (req_divergent_i) begin
                     wid_q    <= req_wid_i;
                     rd_ptr_q <= req_stack_ptr_i;
                     state_q  <= IPDOM_JOIN_RD;
                  end else begin
                     rsp_valid_q     <= 1'b1;
                     rsp_tmask_q     <= req_tmask_i;
                     rsp_pc_en_q     <= 1'b0;
                     rsp_divergent_q <= 1'b0;
                  end
               end
            end
            IPDOM_JOIN_RD: state_q <= IPDOM_JOIN_POP;
            IPDOM_JOIN_POP: begin
               rsp_valid_q     <= 1'b1;
               rsp_wid_q       <= wid_q;
               rsp_divergent_q <= 1'b0;
               if (!stk_q_idx_i) begin
                  rsp_tmask_q <= q_else_tmask;
                  rsp_pc_en_q <= 1'b1;
                  rsp_pc_q    <= q_else_pc;
               end else begin
                  rsp_tmask_q <= q_orig_tmask;
                  rsp_pc_en_q <= 1'b0;
               end
               state_q <= IPDOM_IDLE;
            end
            default: state_q <= IPDOM_IDLE;
         endcase
      end
   end

`ifndef SYNTHESIS
   // Flag stack misuse by the surrounding pipeline.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(stk_push_o && stk_full_i))
            else $error("ipdom: push while stack full");
         assert (!(stk_pop_o && stk_empty_i))
            else $error("ipdom: pop while stack empty");
         assert (!(join_div_fire && (int'(req_stack_ptr_i) >= DEPTH)))
            else $error("ipdom: join stack pointer out of range");
      end
   end
`endif

endmodule

// File: tb/tb_ipdom_split_join_ctrl.sv
// Bench for ipdom_split_join_ctrl: a stack model with 1-cycle registered read
// sits beside the DUT; expectations come from a per-warp reference stack.
module tb_ipdom_split_join_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_is_split, req_divergent;
   logic [1:0]  req_wid;
   logic [3:0]  req_tmask, req_pred;
   logic [31:0] req_else_pc;
   logic [2:0]  req_stack_ptr;
   logic [1:0]  stk_wid;
   logic        stk_push, stk_pop;
   logic [39:0] stk_d_val;
   logic [2:0]  stk_rd_ptr;
   logic [39:0] stk_q_val;
   logic        stk_q_idx;
   logic [11:0] stk_wr_ptr;
   logic        stk_empty, stk_full;
   logic        rsp_valid, rsp_pc_en, rsp_divergent;
   logic [1:0]  rsp_wid;
   logic [3:0]  rsp_tmask;
   logic [31:0] rsp_pc;
   logic [2:0]  rsp_stack_ptr;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ipdom_split_join_ctrl dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_is_split_i(req_is_split),
      .req_wid_i(req_wid), .req_tmask_i(req_tmask), .req_pred_i(req_pred),
      .req_else_pc_i(req_else_pc), .req_divergent_i(req_divergent),
      .req_stack_ptr_i(req_stack_ptr),
      .stk_wid_o(stk_wid), .stk_push_o(stk_push), .stk_pop_o(stk_pop),
      .stk_d_val_o(stk_d_val), .stk_rd_ptr_o(stk_rd_ptr), .stk_q_val_i(stk_q_val),
      .stk_q_idx_i(stk_q_idx), .stk_wr_ptr_i(stk_wr_ptr), .stk_empty_i(stk_empty),
      .stk_full_i(stk_full),
      .rsp_valid_o(rsp_valid), .rsp_wid_o(rsp_wid), .rsp_tmask_o(rsp_tmask),
      .rsp_pc_en_o(rsp_pc_en), .rsp_pc_o(rsp_pc), .rsp_divergent_o(rsp_divergent),
      .rsp_stack_ptr_o(rsp_stack_ptr)
   );

   // ---------------- stack environment (driven by DUT push/pop) ----------------
   logic [39:0] env_mem [4][8];
   logic        env_idx [4][8];
   int          env_cnt [4];

   initial for (int w = 0; w < 4; w++) env_cnt[w] = 0;

   assign stk_full  = (env_cnt[stk_wid] == 8);
   assign stk_empty = (env_cnt[stk_wid] == 0);

   always_comb begin
      stk_wr_ptr = '0;
      for (int i = 0; i < 4; i++) stk_wr_ptr[i*3 +: 3] = env_cnt[i][2:0];
   end

   always @(posedge clk) begin
      stk_q_val <= env_mem[stk_wid][stk_rd_ptr];
      stk_q_idx <= env_idx[stk_wid][stk_rd_ptr];
      if (stk_push && env_cnt[stk_wid] < 8) begin
         env_mem[stk_wid][env_cnt[stk_wid][2:0]] <= stk_d_val;
         env_idx[stk_wid][env_cnt[stk_wid][2:0]] <= 1'b0;
         env_cnt[stk_wid] <= env_cnt[stk_wid] + 1;
      end
      if (stk_pop) begin
         if (!env_idx[stk_wid][stk_rd_ptr]) env_idx[stk_wid][stk_rd_ptr] <= 1'b1;
         else env_cnt[stk_wid] <= int'(stk_rd_ptr);
      end
   end

   // ---------------- reference stack (from request history) ----------------
   logic [3:0]  ref_orig [4][8];
   logic [3:0]  ref_else [4][8];
   logic [31:0] ref_pc   [4][8];
   bit          ref_vis  [4][8];
   int          ref_depth [4];

   initial for (int w = 0; w < 4; w++) ref_depth[w] = 0;

   // SPLIT issued at posedge+1; returns at posedge+1 of the response cycle.
   task automatic do_split(input logic [1:0] w, input logic [3:0] tm, input logic [3:0] pr,
                           input logic [31:0] pc);
      logic [3:0] tk, nt, etm;
      logic dv, epcen;
      logic [2:0] eptr;
      tk = tm & pr;
      nt = tm & ~pr;
      dv = (|tk) && (|nt);
      etm = dv ? tk : tm;
      epcen = (tk == 4'b0);
      eptr = 3'(ref_depth[w]);
      req_valid = 1'b1; req_is_split = 1'b1; req_wid = w; req_tmask = tm;
      req_pred = pr; req_else_pc = pc; req_divergent = 1'b0; req_stack_ptr = 3'd0;
      #3;
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_err++; $display("FAIL split_ready w%0d: got %b want 1", w, req_ready);
      end
      n_cmp++;
      if ({stk_push, stk_pop, stk_wid} !== {dv, 1'b0, w}) begin
         n_err++; $display("FAIL split_push w%0d: got %b want %b", w, {stk_push, stk_pop, stk_wid}, {dv, 1'b0, w});
      end
      if (dv) begin
         n_cmp++;
         if (stk_d_val !== {tm, nt, pc}) begin
            n_err++; $display("FAIL split_dval: got %h want %h", stk_d_val, {tm, nt, pc});
         end
         ref_orig[w][ref_depth[w]] = tm;
         ref_else[w][ref_depth[w]] = nt;
         ref_pc[w][ref_depth[w]]   = pc;
         ref_vis[w][ref_depth[w]]  = 1'b0;
         ref_depth[w]++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_cmp++;
      if ({rsp_valid, rsp_wid, rsp_tmask, rsp_pc_en, rsp_divergent} !== {1'b1, w, etm, epcen, dv}) begin
         n_err++; $display("FAIL split_rsp: got %b want %b",
            {rsp_valid, rsp_wid, rsp_tmask, rsp_pc_en, rsp_divergent}, {1'b1, w, etm, epcen, dv});
      end
      if (epcen) begin
         n_cmp++;
         if (rsp_pc !== pc) begin
            n_err++; $display("FAIL split_pc: got %h want %h", rsp_pc, pc);
         end
      end
      if (dv) begin
         n_cmp++;
         if (rsp_stack_ptr !== eptr) begin
            n_err++; $display("FAIL split_ptr w%0d: got %0d want %0d", w, rsp_stack_ptr, eptr);
         end
      end
   endtask

   // JOIN issued at posedge+1; returns at posedge+1 of the response cycle.
   task automatic do_join(input logic [1:0] w, input logic dv, input logic [2:0] ptr,
                          input logic [3:0] tm);
      logic [3:0] etm;
      logic epcen;
      logic [31:0] epc;
      req_valid = 1'b1; req_is_split = 1'b0; req_wid = w; req_tmask = tm;
      req_pred = 4'h0; req_else_pc = 32'h0; req_divergent = dv; req_stack_ptr = ptr;
      #3;
      n_cmp++;
      if ({req_ready, stk_push, stk_pop} !== 3'b100) begin
         n_err++; $display("FAIL join_accept w%0d: got %b want 100", w, {req_ready, stk_push, stk_pop});
      end
      if (dv) begin
         n_cmp++;
         if ({stk_wid, stk_rd_ptr} !== {w, ptr}) begin
            n_err++; $display("FAIL join_rdaddr: got %b want %b", {stk_wid, stk_rd_ptr}, {w, ptr});
         end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (!dv) begin
         n_cmp++;
         if ({rsp_valid, rsp_wid, rsp_tmask, rsp_pc_en} !== {1'b1, w, tm, 1'b0}) begin
            n_err++; $display("FAIL join_nodiv_rsp: got %b want %b",
               {rsp_valid, rsp_wid, rsp_tmask, rsp_pc_en}, {1'b1, w, tm, 1'b0});
         end
         return;
      end
      n_cmp++;
      if ({rsp_valid, req_ready, stk_pop} !== 3'b000) begin
         n_err++; $display("FAIL join_rd_phase: got %b want 000", {rsp_valid, req_ready, stk_pop});
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({rsp_valid, req_ready, stk_pop, stk_wid, stk_rd_ptr} !== {3'b001, w, ptr}) begin
         n_err++; $display("FAIL join_pop_phase: got %b want %b",
            {rsp_valid, req_ready, stk_pop, stk_wid, stk_rd_ptr}, {3'b001, w, ptr});
      end
      if (!ref_vis[w][ptr]) begin
         etm = ref_else[w][ptr]; epcen = 1'b1; epc = ref_pc[w][ptr];
         ref_vis[w][ptr] = 1'b1;
      end else begin
         etm = ref_orig[w][ptr]; epcen = 1'b0; epc = 32'h0;
         ref_depth[w] = int'(ptr);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({rsp_valid, rsp_wid, rsp_tmask, rsp_pc_en} !== {1'b1, w, etm, epcen}) begin
         n_err++; $display("FAIL join_rsp: got %b want %b",
            {rsp_valid, rsp_wid, rsp_tmask, rsp_pc_en}, {1'b1, w, etm, epcen});
      end
      if (epcen) begin
         n_cmp++;
         if (rsp_pc !== epc) begin
            n_err++; $display("FAIL join_pc: got %h want %h", rsp_pc, epc);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = 1'b1; req_is_split = 1'b1; req_wid = 2'd0; req_tmask = 4'hF;
      req_pred = 4'h3; req_else_pc = 32'h40; req_divergent = 1'b0; req_stack_ptr = 3'd0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({req_ready, stk_push, stk_pop, rsp_valid} !== 4'b0000) begin
         n_err++; $display("FAIL reset_ctrl: got %b want 0000", {req_ready, stk_push, stk_pop, rsp_valid});
      end
      n_cmp++;
      if ({rsp_wid, rsp_tmask, rsp_pc_en, rsp_pc, rsp_divergent, rsp_stack_ptr} !== 43'd0) begin
         n_err++; $display("FAIL reset_data: got %h want 0",
            {rsp_wid, rsp_tmask, rsp_pc_en, rsp_pc, rsp_divergent, rsp_stack_ptr});
      end
      reset = 1'b0; req_valid = 1'b0;
      #3;
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      do_split(2'd0, 4'b1111, 4'b0011, 32'h100);
      do_join(2'd0, 1'b1, 3'd0, 4'b0011);
      do_join(2'd0, 1'b1, 3'd0, 4'b1100);
      n_cmp++;
      if (env_cnt[0] !== 0) begin
         n_err++; $display("FAIL basic_empty_after: got %0d want 0", env_cnt[0]);
      end
      do_split(2'd0, 4'b1111, 4'b1111, 32'h140);
      do_split(2'd0, 4'b1111, 4'b0000, 32'h180);
      do_join(2'd0, 1'b0, 3'd0, 4'b1010);
   endtask

   task automatic test_full();
      for (int i = 0; i < 8; i++)
         do_split(2'd1, 4'b1111, 4'((i % 7) + 1), 32'h400 + 32'(i * 4));
      req_valid = 1'b1; req_is_split = 1'b1; req_wid = 2'd1; req_tmask = 4'hF;
      req_pred = 4'h3; req_else_pc = 32'h4F0; req_divergent = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #3;
         n_cmp++;
         if ({req_ready, stk_push} !== 2'b00) begin
            n_err++; $display("FAIL full_stall c%0d: got %b want 00", c, {req_ready, stk_push});
         end
         @(posedge clk); #1;
         n_cmp++;
         if (rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL full_no_rsp c%0d: got %b want 0", c, rsp_valid);
         end
      end
      do_split(2'd2, 4'b1111, 4'b1111, 32'h500);
      for (int i = 7; i >= 0; i--) begin
         do_join(2'd1, 1'b1, 3'(i), 4'hF);
         do_join(2'd1, 1'b1, 3'(i), 4'hF);
      end
   endtask

   task automatic test_interleave();
      logic [2:0] p0, p1;
      p0 = 3'(ref_depth[0]);
      p1 = 3'(ref_depth[1]);
      do_split(2'd0, 4'b1111, 4'b0101, 32'h200);
      do_split(2'd1, 4'b1010, 4'b1000, 32'h300);
      do_join(2'd0, 1'b1, p0, 4'b0101);
      do_join(2'd0, 1'b1, p0, 4'b1010);
      do_join(2'd1, 1'b1, p1, 4'b1000);
      do_join(2'd1, 1'b1, p1, 4'b0010);
   endtask

   task automatic test_back_to_back();
      logic [1:0] w;
      logic [3:0] pr;
      for (int i = 0; i < 10; i++) begin
         w = 2'($urandom_range(0, 3));
         pr = 4'($urandom);
         if (ref_depth[w] >= 7) pr = 4'hF;
         do_split(w, 4'($urandom), pr, 32'h1000 + 32'(i * 16));
      end
   endtask

   task automatic test_reset_mid_join();
      logic [2:0] p;
      do_split(2'd3, 4'b1111, 4'b1001, 32'h600);
      p = 3'(ref_depth[3] - 1);
      req_valid = 1'b1; req_is_split = 1'b0; req_wid = 2'd3; req_tmask = 4'h9;
      req_divergent = 1'b1; req_stack_ptr = p;
      #3;
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_err++; $display("FAIL rstjoin_accept: got %b want 1", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({stk_pop, rsp_valid, req_ready} !== 3'b000) begin
         n_err++; $display("FAIL rstjoin_in_reset: got %b want 000", {stk_pop, rsp_valid, req_ready});
      end
      reset = 1'b0;
      #3;
      n_cmp++;
      if ({req_ready, stk_pop} !== 2'b10) begin
         n_err++; $display("FAIL rstjoin_idle: got %b want 10", {req_ready, stk_pop});
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({rsp_valid, stk_pop} !== 2'b00) begin
         n_err++; $display("FAIL rstjoin_no_rsp: got %b want 00", {rsp_valid, stk_pop});
      end
      do_join(2'd3, 1'b1, p, 4'h6);
      do_join(2'd3, 1'b1, p, 4'hF);
   endtask

   task automatic test_random();
      logic [1:0] w;
      logic [3:0] pr;
      for (int k = 0; k < 80; k++) begin
         w = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 2) != 0) begin
            pr = 4'($urandom);
            if (ref_depth[w] == 8) pr = 4'hF;
            do_split(w, 4'($urandom), pr, $urandom & 32'hFFFF_FFFC);
         end else if (ref_depth[w] > 0 && $urandom_range(0, 3) != 0) begin
            do_join(w, 1'b1, 3'(ref_depth[w] - 1), 4'($urandom));
         end else begin
            do_join(w, 1'b0, 3'($urandom), 4'($urandom));
         end
      end
   endtask

   initial begin
      req_valid = 1'b0; req_is_split = 1'b0; req_wid = 2'd0; req_tmask = 4'h0;
      req_pred = 4'h0; req_else_pc = 32'h0; req_divergent = 1'b0; req_stack_ptr = 3'd0;
      test_reset();
      test_basic();
      test_full();
      test_interleave();
      test_back_to_back();
      test_reset_mid_join();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
